// File: rtl/polling.sv
// polling: Polling stage of the PIPE link-training controller.
// Runs Polling.Active (TS1) then Polling.Config (TS2), counting transmitted
// and received ordered sets against thresholds and a per-substate timeout,
// and reports success (o_done) or failure (o_fail, back to Detect).
// Optional feature macro: POLLING_COMPLIANCE_EN adds the COMPLIANCE state.
//
// Handshake semantics: i_ts_valid, i_os_err and i_tx_os_done are one-cycle
// strobes with no backpressure; each high cycle is exactly one event.
// o_tx_os_req is a level request: while high the transmitter sends
// o_tx_os_type back to back and strobes i_tx_os_done once per finished set.
module polling #(
  parameter int TX_MIN_ACTIVE = 1024,
  parameter int RX_MIN        = 8,
  parameter int TX_MIN_CONFIG = 16,
  parameter int T_ACTIVE      = 6000000,
  parameter int T_CONFIG      = 12000000
) (
  input  logic       i_core_clk,
  input  logic       i_rstn,
  input  logic       i_start_polling,
  input  logic       i_ts_valid,
  input  logic       i_ts_type,
  input  logic       i_ts_compliance,
  input  logic       i_os_err,
  input  logic       i_tx_os_done,
  input  logic       RxElecIdle,
  output logic       o_tx_os_req,
  output logic [1:0] o_tx_os_type,
  output logic [2:0] PowerDown,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_fail,
  output logic [2:0] o_dbg_state
);

  localparam int TX_MAX = (TX_MIN_ACTIVE > TX_MIN_CONFIG) ? TX_MIN_ACTIVE : TX_MIN_CONFIG;
  localparam int TXW    = $clog2(TX_MAX + 1);
  localparam int RXW    = $clog2(RX_MIN + 1);
  localparam int TMW    = $clog2(T_CONFIG + 1);

  localparam logic [TXW-1:0] TX_ACT_TH  = TXW'(TX_MIN_ACTIVE);
  localparam logic [TXW-1:0] TX_CFG_TH  = TXW'(TX_MIN_CONFIG);
  localparam logic [RXW-1:0] RX_TH      = RXW'(RX_MIN);
  localparam logic [TMW-1:0] T_ACT_LAST = TMW'(T_ACTIVE - 1);
  localparam logic [TMW-1:0] T_CFG_LAST = TMW'(T_CONFIG - 1);

  localparam logic [2:0] PD_P0 = 3'b000;
  localparam logic [2:0] PD_P1 = 3'b010;

  localparam logic [1:0] OS_TS1  = 2'b00;
  localparam logic [1:0] OS_TS2  = 2'b01;

`ifdef POLLING_COMPLIANCE_EN
  localparam logic [1:0] OS_COMP = 2'b10;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACTIVE     = 3'd1,
    ST_CONFIG     = 3'd2,
    ST_EXIT_OK    = 3'd3,
    ST_EXIT_FAIL  = 3'd4,
    ST_COMPLIANCE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACTIVE     = 3'd1,
    ST_CONFIG     = 3'd2,
    ST_EXIT_OK    = 3'd3,
    ST_EXIT_FAIL  = 3'd4
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [TXW-1:0] tx_cnt, tx_d;
  logic [RXW-1:0] rx_cnt, rx_d;
  logic           seen_ts2, seen_d;
  logic [TMW-1:0] timer_q;
  logic           active_ok, config_ok;

`ifdef POLLING_COMPLIANCE_EN
  logic [RXW-1:0] comp_cnt, comp_d;
  logic           comp_hit;
`else
  logic           unused_compliance;
  assign unused_compliance = i_ts_compliance ^ RxElecIdle;
`endif

  assign o_dbg_state = state_q;

  // Counter update values for this cycle; exits are judged on these.
  always_comb begin
    tx_d   = tx_cnt;
    rx_d   = rx_cnt;
    seen_d = seen_ts2;
`ifdef POLLING_COMPLIANCE_EN
    comp_d = comp_cnt;
`endif
    case (state_q)
      ST_ACTIVE: begin
        if (i_tx_os_done && (tx_cnt < TX_ACT_TH)) tx_d = tx_cnt + TXW'(1);
        if (i_os_err) rx_d = '0;
        else if (i_ts_valid && (rx_cnt < RX_TH)) rx_d = rx_cnt + RXW'(1);
`ifdef POLLING_COMPLIANCE_EN
        if (i_os_err || (i_ts_valid && (i_ts_type || !i_ts_compliance))) comp_d = '0;
        else if (i_ts_valid && (comp_cnt < RX_TH)) comp_d = comp_cnt + RXW'(1);
`endif
      end
      ST_CONFIG: begin
        if (i_tx_os_done && seen_ts2 && (tx_cnt < TX_CFG_TH)) tx_d = tx_cnt + TXW'(1);
        if (i_os_err || (i_ts_valid && !i_ts_type)) rx_d = '0;
        else if (i_ts_valid && (rx_cnt < RX_TH)) rx_d = rx_cnt + RXW'(1);
        if (i_ts_valid && i_ts_type) seen_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign active_ok = (tx_d >= TX_ACT_TH) && (rx_d >= RX_TH);
  assign config_ok = (tx_d >= TX_CFG_TH) && (rx_d >= RX_TH);
`ifdef POLLING_COMPLIANCE_EN
  assign comp_hit  = (comp_d >= RX_TH);
`endif

  // Next state and Moore output decode of the current state.
  always_comb begin
    state_d      = state_q;
    o_tx_os_req  = 1'b0;
    o_tx_os_type = OS_TS1;
    PowerDown    = PD_P0;
    o_ready      = 1'b0;
    o_done       = 1'b0;
    o_fail       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready   = 1'b1;
        PowerDown = PD_P1;
        if (i_start_polling) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        o_tx_os_req  = 1'b1;
        o_tx_os_type = OS_TS1;
        if (active_ok) state_d = ST_CONFIG;
`ifdef POLLING_COMPLIANCE_EN
        else if (comp_hit) state_d = ST_COMPLIANCE;
`endif
        else if (timer_q == T_ACT_LAST) state_d = ST_EXIT_FAIL;
      end
      ST_CONFIG: begin
        o_tx_os_req  = 1'b1;
        o_tx_os_type = OS_TS2;
        if (config_ok) state_d = ST_EXIT_OK;
        else if (timer_q == T_CFG_LAST) state_d = ST_EXIT_FAIL;
      end
`ifdef POLLING_COMPLIANCE_EN
      ST_COMPLIANCE: begin
        o_tx_os_req  = 1'b1;
        o_tx_os_type = OS_COMP;
        if (RxElecIdle) state_d = ST_EXIT_FAIL;
      end
`endif
      ST_EXIT_OK: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_EXIT_FAIL: begin
        o_fail  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_core_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Counters and timer: cleared on every state entry, otherwise updated.
  always_ff @(posedge i_core_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      seen_ts2 <= 1'b0;
      timer_q  <= '0;
`ifdef POLLING_COMPLIANCE_EN
      comp_cnt <= '0;
`endif
    end else if (state_d != state_q) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      seen_ts2 <= 1'b0;
      timer_q  <= '0;
`ifdef POLLING_COMPLIANCE_EN
      comp_cnt <= '0;
`endif
    end else begin
      tx_cnt   <= tx_d;
      rx_cnt   <= rx_d;
      seen_ts2 <= seen_d;
`ifdef POLLING_COMPLIANCE_EN
      comp_cnt <= comp_d;
`endif
      if ((state_q == ST_ACTIVE) || (state_q == ST_CONFIG)) timer_q <= timer_q + TMW'(1);
    end
  end

endmodule
